// File: rtl/lr_consistency_check_if.sv
// ============================================================================
// Module   : lr_consistency_check_if
// Purpose  : Pixel stream bundle (stall, row width, L/R disparities, tagged out).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lr_consistency_check_if #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 11
);
    logic              clken;
    logic [AWIDTH-1:0] width;
    logic              in_valid;
    logic [WIDTH-1:0]  disp_l;
    logic [WIDTH-1:0]  disp_r;
    logic [WIDTH+1:0]  dout;
    logic              valid;

    modport master (
        output clken, width, in_valid, disp_l, disp_r,
        input  dout, valid
    );

    modport slave (
        input  clken, width, in_valid, disp_l, disp_r,
        output dout, valid
    );
endinterface

`default_nettype wire

// File: rtl/lr_consistency_check.sv
// ============================================================================
// Module   : lr_consistency_check
// Purpose  : Left-right disparity consistency check; tags each left disparity.
//            Optional macro LRC_SUBPIX_ROUND_EN: round disp_l to nearest pixel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lr_consistency_check #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 4,
    parameter int MAX_DISP  = 64,
    parameter int THRESH    = 16,
    parameter int AWIDTH    = 11
) (
    input  wire logic               clk,
    input  wire logic               rst,
    lr_consistency_check_if.slave   bus
);
    localparam int HW = $clog2(MAX_DISP);
    localparam int DW = WIDTH - FRAC_BITS;
    localparam int CW = ((DW > AWIDTH) ? DW : AWIDTH) + 1;
    localparam logic signed [WIDTH:0] THR_POS = (WIDTH+1)'(THRESH);
    localparam logic signed [WIDTH:0] THR_NEG = -THR_POS;

    localparam logic [1:0] TAG_VALID    = 2'b00;
    localparam logic [1:0] TAG_MISMATCH = 2'b01;
    localparam logic [1:0] TAG_OCCLUDED = 2'b10;
    localparam logic [1:0] TAG_NOFILL   = 2'b11;

    logic [AWIDTH-1:0] x_q, x_d;
    logic [AWIDTH-1:0] width_q;
    logic [WIDTH-1:0]  hist_q [MAX_DISP];

    logic              s1_valid_q;
    logic [WIDTH-1:0]  s1_l_q;
    logic [AWIDTH-1:0] s1_x_q;
    logic [DW-1:0]     s1_dint_q;

    logic [WIDTH+1:0]  dout_q;
    logic              valid_q;

    logic              w_accept;
    logic [AWIDTH-1:0] w_width_eff;
    logic [AWIDTH:0]   w_x_inc;
    logic [DW-1:0]     w_dint;
    logic [HW-1:0]     w_rd_idx;
    logic [WIDTH-1:0]  w_r;
    logic              w_oor;
    logic signed [WIDTH:0] w_diff;
    logic              w_near;
    logic              w_occl;
    logic [1:0]        w_tag;

    assign w_accept    = bus.clken & bus.in_valid;
    // Row length is captured on the first pixel of a row and held for the rest of it.
    assign w_width_eff = (x_q == '0) ? bus.width : width_q;
    assign w_x_inc     = {1'b0, x_q} + 1'b1;
    assign x_d         = (w_x_inc >= {1'b0, w_width_eff}) ? '0 : w_x_inc[AWIDTH-1:0];

`ifdef LRC_SUBPIX_ROUND_EN
    logic [DW:0] w_round;
    assign w_round = {1'b0, bus.disp_l[WIDTH-1:FRAC_BITS]} + (DW+1)'(bus.disp_l[FRAC_BITS-1]);
    assign w_dint  = w_round[DW] ? '1 : w_round[DW-1:0];
`else
    assign w_dint  = bus.disp_l[WIDTH-1:FRAC_BITS];
`endif

    // History is written on the accept edge, so S2 one cycle later already sees
    // the same-pixel disp_r for d = 0 without a separate forwarding path.
    assign w_rd_idx = s1_x_q[HW-1:0] - s1_dint_q[HW-1:0];
    assign w_r      = hist_q[w_rd_idx];
    assign w_oor    = (CW'(s1_dint_q) >= CW'(MAX_DISP)) || (CW'(s1_dint_q) > CW'(s1_x_q));
    assign w_diff   = $signed({1'b0, s1_l_q}) - $signed({1'b0, w_r});
    assign w_near   = (w_diff <= THR_POS) && (w_diff >= THR_NEG);
    assign w_occl   = {2'b00, w_r} > ({2'b00, s1_l_q} + (WIDTH+2)'(THRESH));

    always_comb begin
        w_tag = TAG_MISMATCH;
        if (w_oor) begin
            w_tag = TAG_NOFILL;
        end else if (w_near) begin
            w_tag = TAG_VALID;
        end else if (w_occl) begin
            w_tag = TAG_OCCLUDED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            width_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_l_q     <= '0;
            s1_x_q     <= '0;
            s1_dint_q  <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            for (int i = 0; i < MAX_DISP; i++) begin
                hist_q[i] <= '0;
            end
        end else if (bus.clken) begin
            s1_valid_q <= bus.in_valid;
            valid_q    <= s1_valid_q;
            if (w_accept) begin
                x_q                  <= x_d;
                hist_q[x_q[HW-1:0]]  <= bus.disp_r;
                s1_l_q               <= bus.disp_l;
                s1_x_q               <= x_q;
                s1_dint_q            <= w_dint;
                if (x_q == '0) begin
                    width_q <= bus.width;
                end
            end
            if (s1_valid_q) begin
                dout_q <= {w_tag, s1_l_q};
            end
        end
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_lr_consistency_check.sv
// ============================================================================
// Module   : tb_lr_consistency_check
// Purpose  : Directed self-checking bench for lr_consistency_check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lr_consistency_check;
    logic clk = 1'b0;
    logic rst = 1'b1;

    lr_consistency_check_if #(.WIDTH(16), .AWIDTH(11)) bus ();

    lr_consistency_check #(
        .WIDTH(16), .FRAC_BITS(4), .MAX_DISP(64), .THRESH(16), .AWIDTH(11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [17:0] pend  = '0;
    logic [17:0] last  = '0;
    bit          have_pend = 1'b0;

    logic [15:0] rb_l [12] = '{16'h0000, 16'h0000, 16'h0070, 16'h0000, 16'h0051, 16'h0040,
                               16'h0030, 16'h0050, 16'h0040, 16'h0040, 16'h0400, 16'h0010};
    logic [15:0] rb_r [12] = '{16'h0000, 16'h0050, 16'h0061, 16'h0060, 16'h0051, 16'h002F,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234};
    logic [1:0]  rb_t [12] = '{2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00,
                               2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00};
    logic [1:0]  ra_t [8]  = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    logic [15:0] rc_l [8]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0030, 16'h0000};
    logic [15:0] rc_r [8]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0010,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [1:0]  rc_t [8]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};

    task automatic check(input string name, input logic [18:0] obs, input logic [18:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed {valid,dout}=%h expected %h", name, obs, exp);
        end
    endtask

    task automatic cyc(input logic ce, input logic iv, input logic [15:0] l, input logic [15:0] r);
        bus.clken    = ce;
        bus.in_valid = iv;
        bus.disp_l   = l;
        bus.disp_r   = r;
        @(posedge clk);
        #1;
    endtask

    // Streamed pixel: the result of the previous pixel appears one enabled cycle later.
    task automatic px(input string name, input logic [15:0] l, input logic [15:0] r,
                      input logic [1:0] tag);
        cyc(1'b1, 1'b1, l, r);
        if (have_pend) begin
            check(name, {1'b1, bus.dout}, {1'b1, pend});
            check({name, " valid"}, {18'd0, bus.valid}, 19'd1);
            last = pend;
        end else begin
            check(name, {bus.valid, bus.dout}, {1'b0, last});
        end
        pend      = {tag, l};
        have_pend = 1'b1;
    endtask

    task automatic flush(input string name);
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000);
        if (have_pend) begin
            check(name, {bus.valid, bus.dout}, {1'b1, pend});
            last = pend;
        end else begin
            check(name, {bus.valid, bus.dout}, {1'b0, last});
        end
        have_pend = 1'b0;
    endtask

    // Gapped pixel: accept, stall with junk on the inputs, then a bubble.
    task automatic pxg(input string name, input logic [15:0] l, input logic [15:0] r,
                       input logic [1:0] tag);
        cyc(1'b1, 1'b1, l, r);
        check({name, " accept"}, {bus.valid, bus.dout}, {1'b0, last});
        cyc(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
        check({name, " hold"}, {bus.valid, bus.dout}, {1'b0, last});
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000);
        check({name, " out"}, {bus.valid, bus.dout}, {1'b1, tag, l});
        last = {tag, l};
    endtask

    initial begin
        bus.clken    = 1'b0;
        bus.in_valid = 1'b0;
        bus.disp_l   = '0;
        bus.disp_r   = '0;
        bus.width    = 11'd8;
        repeat (2) @(posedge clk);
        #1;
        check("reset", {bus.valid, bus.dout}, 19'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
        check("idle", {bus.valid, bus.dout}, 19'd0);

        // Flat row, width 8, disparity 5.0 px
        for (int c = 0; c < 8; c++) px($sformatf("flat c%0d", c), 16'h0050, 16'h0050, ra_t[c]);
        flush("flat flush");
        flush("flat bubble hold");

        // Mixed row, width 12, then the same row with gaps and stalls
        bus.width = 11'd12;
        for (int c = 0; c < 12; c++) px($sformatf("rowB c%0d", c), rb_l[c], rb_r[c], rb_t[c]);
        flush("rowB flush");
        for (int c = 0; c < 12; c++) pxg($sformatf("rowB gap c%0d", c), rb_l[c], rb_r[c], rb_t[c]);

        // Mismatch row, width 8; width change mid-row must not shorten/extend it
        bus.width = 11'd8;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) bus.width = 11'd128;
            px($sformatf("rowC c%0d", c), rc_l[c], rc_r[c], rc_t[c]);
        end
        flush("rowC flush");

        // Wide row: out-of-range at x = 100, dint 63 in range at x = 101
        px("range c0", 16'h0010, 16'h0000, 2'b11);
        for (int c = 1; c < 100; c++) px($sformatf("range c%0d", c), 16'h0000, 16'h0000, 2'b00);
        px("range c100", 16'h0400, 16'h0000, 2'b11);
        px("range c101", 16'h03F0, 16'h0000, 2'b01);
        flush("range flush");
        px("range c102", 16'h0000, 16'h0000, 2'b00);

        // Asynchronous reset mid-row
        rst = 1'b1;
        #1;
        check("async reset", {bus.valid, bus.dout}, 19'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        have_pend = 1'b0;
        last      = '0;
        bus.width = 11'd8;

        px("post-rst c0", 16'h0010, 16'h0038, 2'b11);
        px("post-rst c1", 16'h0000, 16'h0000, 2'b00);
        px("post-rst c2", 16'h0000, 16'h0000, 2'b00);
`ifdef LRC_SUBPIX_ROUND_EN
        px("round c3", 16'h0038, 16'h0000, 2'b11);
`else
        px("trunc c3", 16'h0038, 16'h0000, 2'b00);
`endif
        flush("post-rst flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
